// File: rtl/rep_string_sequencer.sv
// Iterating controller for x86 string instructions (MOVS/STOS/LODS/CMPS/SCAS with REP prefixes).
// Issues one ESI/EDI element access per iteration, steps the pointers/count, and reports final state.
module rep_string_sequencer #(
    parameter int MAX_ITERS = 0,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        cmd,
    input  logic [1:0]        rep_kind,
    input  logic              df,
    input  logic [1:0]        size,
    input  logic [31:0]       eax_in,
    input  logic [ADDR_W-1:0] ecx_in,
    input  logic [ADDR_W-1:0] esi_in,
    input  logic [ADDR_W-1:0] edi_in,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    output logic [1:0]        mem_req_size,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_rdata,
    output logic              busy,
    output logic              done,
    output logic              truncated,
    output logic              illegal,
    output logic [31:0]       eax_out,
    output logic [ADDR_W-1:0] ecx_out,
    output logic [ADDR_W-1:0] esi_out,
    output logic [ADDR_W-1:0] edi_out,
    output logic              zf_out
);
    typedef enum logic [2:0] {IDLE, CHECK, RD_SRC, RD_DST, WR_DST, STEP, FIN} state_t;

    localparam logic [2:0] C_MOVS = 3'd0;
    localparam logic [2:0] C_STOS = 3'd1;
    localparam logic [2:0] C_LODS = 3'd2;
    localparam logic [2:0] C_CMPS = 3'd3;
    localparam logic [2:0] C_SCAS = 3'd4;

    function automatic logic [31:0] mask_elem(input logic [31:0] d, input logic [1:0] sz);
        case (sz)
            2'd0:    mask_elem = {24'd0, d[7:0]};
            2'd1:    mask_elem = {16'd0, d[15:0]};
            default: mask_elem = d;
        endcase
    endfunction

    function automatic logic [31:0] merge_eax(input logic [31:0] a, input logic [31:0] d,
                                              input logic [1:0] sz);
        case (sz)
            2'd0:    merge_eax = {a[31:8], d[7:0]};
            2'd1:    merge_eax = {a[31:16], d[15:0]};
            default: merge_eax = d;
        endcase
    endfunction

    function automatic logic signed [ADDR_W-1:0] step_delta(input logic [1:0] sz, input logic dir);
        logic signed [ADDR_W-1:0] mag;
        mag = '0;
        case (sz)
            2'd0:    mag[2:0] = 3'd1;
            2'd1:    mag[2:0] = 3'd2;
            default: mag[2:0] = 3'd4;
        endcase
        step_delta = dir ? -mag : mag;
    endfunction

    state_t              state, next_state;
    logic [2:0]          cmd_r;
    logic [1:0]          rep_r, size_r;
    logic                df_r, ill_r, pend;
    logic [31:0]         iter;
    logic [31:0]         eax_r, src_r;
    logic [ADDR_W-1:0]   ecx_r, esi_r, edi_r;
    logic                zf_r, trunc_hit;

    logic                uses_src, uses_dst, is_cmp, rsp_take;
    logic signed [ADDR_W-1:0] delta;
    logic [ADDR_W-1:0]   esi_nx, edi_nx, ecx_nx;

    always_comb begin
        uses_src = (cmd_r == C_MOVS) || (cmd_r == C_LODS) || (cmd_r == C_CMPS);
        uses_dst = (cmd_r != C_LODS);
        is_cmp   = (cmd_r == C_CMPS) || (cmd_r == C_SCAS);
        rsp_take = pend && mem_rsp_valid;
        delta    = step_delta(size_r, df_r);
        esi_nx   = esi_r;
        edi_nx   = edi_r;
        ecx_nx   = ecx_r;
        if (state == STEP) begin
            if (uses_src)      esi_nx = esi_r + $unsigned(delta);
            if (uses_dst)      edi_nx = edi_r + $unsigned(delta);
            if (rep_r != 2'd0) ecx_nx = ecx_r - ADDR_W'(1);
        end
    end

    // Next-state and memory request decode; request fields depend only on latched state.
    always_comb begin
        next_state    = state;
        trunc_hit     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        case (state)
            IDLE:   if (start) next_state = CHECK;
            CHECK: begin
                if (ill_r)                                    next_state = FIN;
                else if (rep_r != 2'd0 && ecx_r == '0)        next_state = FIN;
                else if (rep_r == 2'd0 && iter != 32'd0)      next_state = FIN;
                else if (MAX_ITERS != 0 && iter == 32'(MAX_ITERS)) begin
                    next_state = FIN;
                    trunc_hit  = 1'b1;
                end
                else if (cmd_r == C_SCAS)                     next_state = RD_DST;
                else if (cmd_r == C_STOS)                     next_state = WR_DST;
                else                                          next_state = RD_SRC;
            end
            RD_SRC: begin
                mem_req_valid = !pend;
                mem_req_addr  = esi_r;
                if (rsp_take) begin
                    if (cmd_r == C_MOVS)      next_state = WR_DST;
                    else if (cmd_r == C_CMPS) next_state = RD_DST;
                    else                      next_state = STEP;
                end
            end
            RD_DST: begin
                mem_req_valid = !pend;
                mem_req_addr  = edi_r;
                if (rsp_take) next_state = STEP;
            end
            WR_DST: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = edi_r;
                mem_req_wdata = (cmd_r == C_MOVS) ? src_r : mask_elem(eax_r, size_r);
                if (mem_req_ready) next_state = STEP;
            end
            STEP: begin
                if (is_cmp && ((rep_r == 2'd1 && !zf_r) || (rep_r == 2'd2 && zf_r)))
                    next_state = FIN;
                else
                    next_state = CHECK;
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign mem_req_size = size_r;
    assign busy         = (state != IDLE);
    assign done         = (state == FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pend   <= 1'b0;
            cmd_r  <= '0;
            rep_r  <= '0;
            size_r <= '0;
            df_r   <= 1'b0;
            ill_r  <= 1'b0;
            iter   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                cmd_r  <= cmd;
                rep_r  <= rep_kind;
                size_r <= size;
                df_r   <= df;
                ill_r  <= (cmd > C_SCAS) || (size == 2'd3) || (rep_kind == 2'd3);
                iter   <= '0;
            end
            if (state == STEP) iter <= iter + 32'd1;
            // A response in the acceptance cycle is ignored: pend only rises after acceptance.
            if (state == RD_SRC || state == RD_DST) begin
                if (!pend && mem_req_ready) pend <= 1'b1;
                else if (rsp_take)          pend <= 1'b0;
            end else begin
                pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (start) begin
                eax_r <= eax_in;
                ecx_r <= ecx_in;
                esi_r <= esi_in;
                edi_r <= edi_in;
                zf_r  <= zf_out;
            end
            RD_SRC: if (rsp_take) begin
                if (cmd_r == C_LODS) eax_r <= merge_eax(eax_r, mem_rsp_rdata, size_r);
                else                 src_r <= mask_elem(mem_rsp_rdata, size_r);
            end
            RD_DST: if (rsp_take) begin
                if (cmd_r == C_CMPS) zf_r <= (src_r == mask_elem(mem_rsp_rdata, size_r));
                else zf_r <= (mask_elem(eax_r, size_r) == mask_elem(mem_rsp_rdata, size_r));
            end
            STEP: begin
                esi_r <= esi_nx;
                edi_r <= edi_nx;
                ecx_r <= ecx_nx;
            end
            default: ;
        endcase
    end

    // Architectural results are captured on entry to FIN so they are valid alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eax_out   <= '0;
            ecx_out   <= '0;
            esi_out   <= '0;
            edi_out   <= '0;
            zf_out    <= 1'b0;
            truncated <= 1'b0;
            illegal   <= 1'b0;
        end else if (next_state == FIN && state != FIN) begin
            eax_out   <= eax_r;
            ecx_out   <= ecx_nx;
            esi_out   <= esi_nx;
            edi_out   <= edi_nx;
            zf_out    <= zf_r;
            truncated <= trunc_hit;
            illegal   <= ill_r;
        end
    end
endmodule

// File: tb/tb_rep_string_sequencer.sv
// Directed bench for rep_string_sequencer with a byte-addressed memory responder
// whose accept and response delays are adjustable per scenario.
module tb_rep_string_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, start2 = 1'b0;
    logic [2:0]  cmd = '0;
    logic [1:0]  rep_kind = '0, size = '0;
    logic        df = 1'b0;
    logic [31:0] eax_in = '0, ecx_in = '0, esi_in = '0, edi_in = '0;

    logic        mem_req_valid, mem_req_write;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [1:0]  mem_req_size;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        busy, done, truncated, illegal, zf_out;
    logic [31:0] eax_out, ecx_out, esi_out, edi_out;

    logic        v2, w2, busy2, done2, trunc2, ill2, zf2;
    logic [31:0] a2, wd2, eax2, ecx2, esi2, edi2;
    logic [1:0]  sz2;
    logic        ready2 = 1'b1, rspv2 = 1'b0;
    logic [31:0] rdata2 = '0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rep_string_sequencer #(.MAX_ITERS(0), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .rep_kind(rep_kind), .df(df),
        .size(size), .eax_in(eax_in), .ecx_in(ecx_in), .esi_in(esi_in), .edi_in(edi_in),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_size(mem_req_size),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .busy(busy), .done(done), .truncated(truncated), .illegal(illegal),
        .eax_out(eax_out), .ecx_out(ecx_out), .esi_out(esi_out), .edi_out(edi_out),
        .zf_out(zf_out)
    );

    rep_string_sequencer #(.MAX_ITERS(2), .ADDR_W(32)) dut_cap (
        .clk(clk), .rst_n(rst_n), .start(start2), .cmd(cmd), .rep_kind(rep_kind), .df(df),
        .size(size), .eax_in(eax_in), .ecx_in(ecx_in), .esi_in(esi_in), .edi_in(edi_in),
        .mem_req_valid(v2), .mem_req_ready(ready2), .mem_req_write(w2), .mem_req_addr(a2),
        .mem_req_wdata(wd2), .mem_req_size(sz2), .mem_rsp_valid(rspv2),
        .mem_rsp_rdata(rdata2), .busy(busy2), .done(done2), .truncated(trunc2),
        .illegal(ill2), .eax_out(eax2), .ecx_out(ecx2), .esi_out(esi2), .edi_out(edi2),
        .zf_out(zf2)
    );

    logic [7:0]  mem [logic [31:0]];
    logic [31:0] wr_addr_q[$], wr_data_q[$];
    int          ready_dly = 0, rsp_dly = 0;
    int          wait_cnt = 0, rsp_cnt = 0, req_cycles = 0, acc_cnt = 0, wr2_cnt = 0;
    logic [31:0] rsp_data = '0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            if (mem.exists(a + 32'(i))) w[8*i +: 8] = mem[a + 32'(i)];
        return w;
    endfunction

    always @(negedge clk) begin
        mem_rsp_valid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = rsp_data;
            end
        end
        if (mem_req_valid) req_cycles++;
        mem_req_ready = mem_req_valid && (wait_cnt >= ready_dly);
        if (mem_req_valid && !mem_req_ready) wait_cnt++;
        if (mem_req_valid && mem_req_ready) begin
            wait_cnt = 0;
            acc_cnt++;
            if (mem_req_write) begin
                wr_addr_q.push_back(mem_req_addr);
                wr_data_q.push_back(mem_req_wdata);
            end else begin
                rsp_data = rd_word(mem_req_addr);
                rsp_cnt  = rsp_dly + 1;
            end
        end
        if (v2 && ready2 && w2) wr2_cnt++;
    end

    task automatic launch(input logic [2:0] c, input logic [1:0] rk, input logic d,
                          input logic [1:0] sz, input logic [31:0] a, input logic [31:0] cx,
                          input logic [31:0] si, input logic [31:0] di);
        @(negedge clk);
        cmd = c; rep_kind = rk; df = d; size = sz;
        eax_in = a; ecx_in = cx; esi_in = si; edi_in = di;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc, output bit to);
        cyc = 1;
        to  = 1'b0;
        while (done !== 1'b1) begin
            if (cyc >= max) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", mem_req_valid); end
        n_checks++; if ({eax_out, ecx_out, esi_out, edi_out} !== 128'd0) begin n_fail++; $display("FAIL reset_regs got %h %h %h %h exp 0", eax_out, ecx_out, esi_out, edi_out); end
        n_checks++; if ({zf_out, truncated, illegal} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {zf_out, truncated, illegal}); end
        rst_n = 1'b1;
    endtask

    task automatic test_rep_stos();
        int cyc; bit to; int w0;
        w0 = wr_addr_q.size();
        launch(3'd1, 2'd1, 1'b0, 2'd2, 32'hAABBCCDD, 32'd3, 32'h5555, 32'h1000);
        wait_done(100, cyc, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL stos_done got timeout exp done"); end
        n_checks++; if (wr_addr_q.size() - w0 !== 3) begin n_fail++; $display("FAIL stos_nwr got %0d exp 3", wr_addr_q.size() - w0); end
        for (int i = 0; i < 3 && w0 + i < wr_addr_q.size(); i++) begin
            n_checks++; if (wr_addr_q[w0+i] !== 32'h1000 + 32'(4*i) || wr_data_q[w0+i] !== 32'hAABBCCDD) begin n_fail++; $display("FAIL stos_wr%0d got %h@%h exp aabbccdd@%h", i, wr_data_q[w0+i], wr_addr_q[w0+i], 32'h1000 + 32'(4*i)); end
        end
        n_checks++; if (edi_out !== 32'h100C || ecx_out !== 32'd0) begin n_fail++; $display("FAIL stos_regs got edi=%h ecx=%h exp 100c 0", edi_out, ecx_out); end
        n_checks++; if (esi_out !== 32'h5555 || eax_out !== 32'hAABBCCDD) begin n_fail++; $display("FAIL stos_keep got esi=%h eax=%h exp 5555 aabbccdd", esi_out, eax_out); end
        n_checks++; if (truncated !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL stos_flags got t=%b i=%b exp 0 0", truncated, illegal); end
    endtask

    task automatic test_rep_movs();
        int cyc; bit to; int w0;
        mem[32'h2001] = 8'h11; mem[32'h2000] = 8'h22; mem[32'h2002] = 8'hEE;
        w0 = wr_addr_q.size();
        launch(3'd0, 2'd1, 1'b1, 2'd0, 32'h0, 32'd2, 32'h2001, 32'h3001);
        wait_done(100, cyc, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL movs_done got timeout exp done"); end
        n_checks++; if (wr_addr_q.size() - w0 !== 2) begin n_fail++; $display("FAIL movs_nwr got %0d exp 2", wr_addr_q.size() - w0); end
        if (wr_addr_q.size() - w0 >= 2) begin
            n_checks++; if (wr_addr_q[w0] !== 32'h3001 || wr_data_q[w0] !== 32'h11) begin n_fail++; $display("FAIL movs_wr0 got %h@%h exp 11@3001", wr_data_q[w0], wr_addr_q[w0]); end
            n_checks++; if (wr_addr_q[w0+1] !== 32'h3000 || wr_data_q[w0+1] !== 32'h22) begin n_fail++; $display("FAIL movs_wr1 got %h@%h exp 22@3000", wr_data_q[w0+1], wr_addr_q[w0+1]); end
        end
        n_checks++; if (esi_out !== 32'h1FFF || edi_out !== 32'h2FFF || ecx_out !== 32'd0) begin n_fail++; $display("FAIL movs_regs got esi=%h edi=%h ecx=%h exp 1fff 2fff 0", esi_out, edi_out, ecx_out); end
    endtask

    task automatic test_repne_scas();
        int cyc; bit to; int a0;
        mem[32'h6000] = 8'h10; mem[32'h6001] = 8'h77;
        a0 = acc_cnt;
        launch(3'd4, 2'd2, 1'b0, 2'd0, 32'h12345677, 32'd4, 32'hABCD, 32'h6000);
        wait_done(100, cyc, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL scas_done got timeout exp done"); end
        n_checks++; if (acc_cnt - a0 !== 2) begin n_fail++; $display("FAIL scas_nrd got %0d exp 2", acc_cnt - a0); end
        n_checks++; if (zf_out !== 1'b1) begin n_fail++; $display("FAIL scas_zf got %b exp 1", zf_out); end
        n_checks++; if (ecx_out !== 32'd2 || edi_out !== 32'h6002 || esi_out !== 32'hABCD) begin n_fail++; $display("FAIL scas_regs got ecx=%h edi=%h esi=%h exp 2 6002 abcd", ecx_out, edi_out, esi_out); end
    endtask

    task automatic test_stos_latency();
        int cyc; bit to; int w0;
        w0 = wr_addr_q.size();
        launch(3'd1, 2'd0, 1'b0, 2'd0, 32'h123456F0, 32'd7, 32'h0, 32'h40);
        wait_done(100, cyc, to);
        n_checks++; if (to || cyc !== 5) begin n_fail++; $display("FAIL stos1_latency got %0d exp 5", cyc); end
        n_checks++; if (wr_addr_q.size() - w0 !== 1 || wr_data_q[w0] !== 32'hF0 || wr_addr_q[w0] !== 32'h40) begin n_fail++; $display("FAIL stos1_wr got n=%0d exp one f0@40", wr_addr_q.size() - w0); end
        n_checks++; if (edi_out !== 32'h41 || ecx_out !== 32'd7) begin n_fail++; $display("FAIL stos1_regs got edi=%h ecx=%h exp 41 7", edi_out, ecx_out); end
        n_checks++; if (zf_out !== 1'b1) begin n_fail++; $display("FAIL stos1_zf_kept got %b exp 1", zf_out); end
    endtask

    task automatic test_zero_count();
        int cyc; bit to; int r0;
        r0 = req_cycles;
        launch(3'd1, 2'd1, 1'b0, 2'd2, 32'hCAFE0001, 32'd0, 32'h111, 32'h222);
        wait_done(50, cyc, to);
        n_checks++; if (to || cyc !== 2) begin n_fail++; $display("FAIL zc_stos_latency got %0d exp 2", cyc); end
        n_checks++; if ({eax_out, ecx_out, esi_out, edi_out} !== {32'hCAFE0001, 32'd0, 32'h111, 32'h222}) begin n_fail++; $display("FAIL zc_stos_regs got %h %h %h %h", eax_out, ecx_out, esi_out, edi_out); end
        launch(3'd4, 2'd2, 1'b1, 2'd1, 32'h5A5A, 32'd0, 32'h333, 32'h444);
        wait_done(50, cyc, to);
        n_checks++; if (to || cyc !== 2) begin n_fail++; $display("FAIL zc_scas_latency got %0d exp 2", cyc); end
        n_checks++; if (edi_out !== 32'h444 || ecx_out !== 32'd0 || zf_out !== 1'b1) begin n_fail++; $display("FAIL zc_scas_regs got edi=%h ecx=%h zf=%b exp 444 0 1", edi_out, ecx_out, zf_out); end
        n_checks++; if (req_cycles !== r0) begin n_fail++; $display("FAIL zc_no_req got %0d exp 0", req_cycles - r0); end
    endtask

    task automatic test_repe_cmps();
        int cyc; bit to; int a0;
        mem[32'h4000] = 8'hEF; mem[32'h4001] = 8'hBE; mem[32'h5000] = 8'hEF; mem[32'h5001] = 8'hBE;
        mem[32'h4002] = 8'h34; mem[32'h4003] = 8'h12; mem[32'h5002] = 8'h35; mem[32'h5003] = 8'h12;
        a0 = acc_cnt;
        launch(3'd3, 2'd1, 1'b0, 2'd1, 32'h0, 32'd5, 32'h4000, 32'h5000);
        wait_done(100, cyc, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL cmps_done got timeout exp done"); end
        n_checks++; if (acc_cnt - a0 !== 4) begin n_fail++; $display("FAIL cmps_nrd got %0d exp 4", acc_cnt - a0); end
        n_checks++; if (ecx_out !== 32'd3 || zf_out !== 1'b0) begin n_fail++; $display("FAIL cmps_res got ecx=%h zf=%b exp 3 0", ecx_out, zf_out); end
        n_checks++; if (esi_out !== 32'h4004 || edi_out !== 32'h5004) begin n_fail++; $display("FAIL cmps_ptr got esi=%h edi=%h exp 4004 5004", esi_out, edi_out); end
    endtask

    task automatic test_lods_stall();
        int cyc; int vcnt; logic [66:0] first;
        mem[32'h7000] = 8'h9A; mem[32'h7001] = 8'hFF; mem[32'h7002] = 8'hFF; mem[32'h7003] = 8'hFF;
        ready_dly = 4; rsp_dly = 3; vcnt = 0; first = '0;
        launch(3'd2, 2'd0, 1'b0, 2'd0, 32'h12345678, 32'd9, 32'h7000, 32'h0);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            if (mem_req_valid === 1'b1) begin
                vcnt++;
                if (vcnt == 1) first = {mem_req_addr, mem_req_write, mem_req_wdata, mem_req_size};
                else begin
                    n_checks++; if ({mem_req_addr, mem_req_write, mem_req_wdata, mem_req_size} !== first) begin n_fail++; $display("FAIL lods_hold got %h exp %h", {mem_req_addr, mem_req_write, mem_req_wdata, mem_req_size}, first); end
                end
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (done !== 1'b1 || cyc !== 13) begin n_fail++; $display("FAIL lods_latency got %0d exp 13", cyc); end
        n_checks++; if (vcnt !== 5 || first !== {32'h7000, 1'b0, 32'h0, 2'd0}) begin n_fail++; $display("FAIL lods_req got n=%0d f=%h exp 5 7000 rd byte", vcnt, first); end
        n_checks++; if (eax_out !== 32'h1234569A || esi_out !== 32'h7001) begin n_fail++; $display("FAIL lods_regs got eax=%h esi=%h exp 1234569a 7001", eax_out, esi_out); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL lods_illegal got %b exp 0", illegal); end
        ready_dly = 0; rsp_dly = 0;
    endtask

    task automatic test_reset_mid();
        int cyc; bit to; int dcnt; int w0;
        rsp_dly = 30;
        launch(3'd2, 2'd0, 1'b0, 2'd0, 32'h55, 32'd1, 32'h7000, 32'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({busy, done, mem_req_valid} !== 3'b000) begin n_fail++; $display("FAIL rstmid_ctl got %b exp 000", {busy, done, mem_req_valid}); end
        n_checks++; if ({eax_out, esi_out, zf_out} !== 65'd0) begin n_fail++; $display("FAIL rstmid_regs got eax=%h esi=%h zf=%b exp 0", eax_out, esi_out, zf_out); end
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (35) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        n_checks++; if (dcnt !== 0) begin n_fail++; $display("FAIL rstmid_nodone got %0d active cycles exp 0", dcnt); end
        rsp_dly = 0;
        w0 = wr_addr_q.size();
        launch(3'd1, 2'd0, 1'b0, 2'd0, 32'h3C, 32'd0, 32'h0, 32'h9000);
        wait_done(50, cyc, to);
        n_checks++; if (to || cyc !== 5) begin n_fail++; $display("FAIL rstmid_fresh_lat got %0d exp 5", cyc); end
        n_checks++; if (edi_out !== 32'h9001 || wr_addr_q.size() - w0 !== 1 || wr_data_q[w0] !== 32'h3C) begin n_fail++; $display("FAIL rstmid_fresh got edi=%h nwr=%0d exp 9001 1", edi_out, wr_addr_q.size() - w0); end
    endtask

    task automatic test_illegal();
        int cyc; bit to; int r0;
        logic [2:0] c_tab [3] = '{3'd5, 3'd1, 3'd1};
        logic [1:0] r_tab [3] = '{2'd0, 2'd0, 2'd3};
        logic [1:0] s_tab [3] = '{2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 3; i++) begin
            r0 = req_cycles;
            launch(c_tab[i], r_tab[i], 1'b0, s_tab[i], 32'hD00D0000 + 32'(i), 32'd4, 32'hE0, 32'hF0);
            wait_done(50, cyc, to);
            n_checks++; if (to || illegal !== 1'b1) begin n_fail++; $display("FAIL ill%0d_flag got %b exp 1", i, illegal); end
            n_checks++; if (req_cycles !== r0 || eax_out !== 32'hD00D0000 + 32'(i) || ecx_out !== 32'd4 || edi_out !== 32'hF0) begin n_fail++; $display("FAIL ill%0d_state got req=%0d eax=%h ecx=%h edi=%h", i, req_cycles - r0, eax_out, ecx_out, edi_out); end
        end
    endtask

    task automatic test_max_iters();
        int cyc; int w0;
        w0 = wr2_cnt;
        @(negedge clk);
        cmd = 3'd1; rep_kind = 2'd1; df = 1'b0; size = 2'd2;
        eax_in = 32'h0BADF00D; ecx_in = 32'd10; esi_in = 32'h0; edi_in = 32'h8000;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (done2 !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL cap_done got timeout exp done"); end
        n_checks++; if (wr2_cnt - w0 !== 2) begin n_fail++; $display("FAIL cap_nwr got %0d exp 2", wr2_cnt - w0); end
        n_checks++; if (trunc2 !== 1'b1) begin n_fail++; $display("FAIL cap_trunc got %b exp 1", trunc2); end
        n_checks++; if (ecx2 !== 32'd8 || edi2 !== 32'h8008) begin n_fail++; $display("FAIL cap_regs got ecx=%h edi=%h exp 8 8008", ecx2, edi2); end
    endtask

    initial begin
        test_reset();
        test_rep_stos();
        test_rep_movs();
        test_repne_scas();
        test_stos_latency();
        test_zero_count();
        test_repe_cmps();
        test_lods_stall();
        test_reset_mid();
        test_illegal();
        test_max_iters();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
